uart_fifo_tx: RTL
=================

Name: uart_fifo_tx

Overview:
- UART transmitter that drains bytes from a first-word-fall-through FIFO and serializes each byte onto the tx line as LSB-first frames: start bit, 8 data bits, optional parity bit, 1 or 2 stop bits.
- Sits between a Tx-side FIFO and the top-level tx pin, and replaces the transmit half of the combined uart block.
- Fetches the next byte itself, so back-to-back bytes leave with no idle gap between frames.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate. Bit period BIT_CYC = CLK_FREQ/BAUD_RATE cycles, integer division, truncated.
- PARITY_EN, 0: 1 inserts a parity bit after D7.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low.
- fifo_empty  input  1  source FIFO empty flag.
- fifo_rdata  input  8  source FIFO head byte; valid combinationally whenever fifo_empty = 0.
- fifo_rd  output  1  one-cycle pop strobe to the source FIFO.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is being sent.
- tx_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (rst = 0 at a clock edge), takes effect on that edge:
  - tx = 1, tx_busy = 0, tx_done = 0, fifo_rd = 0.
  - state = IDLE; bit counter, baud counter and shift register cleared.
- Reset mid-frame aborts the frame: tx returns high on the next edge. The popped byte is lost and is not re-fetched.
- Baud counter:
  - Counts 0..BIT_CYC-1 and restarts at 0 on every state entry.
  - Each line bit lasts exactly BIT_CYC clock cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1, tx_busy = 0.
  - On fifo_empty = 0: in the same cycle assert fifo_rd = 1 (exactly one cycle) and latch fifo_rdata into the shift register.
  - Go to START on the next edge.
- START: tx = 0 for BIT_CYC cycles, then DATA.
- DATA:
  - tx = shreg[0]; shift right at each bit end.
  - 3-bit bit index; after bit 7 go to PARITY if PARITY_EN = 1, else STOP.
- PARITY:
  - tx = XOR of the 8 latched bits, XORed with PARITY_ODD.
  - Parity is computed from a copy latched at fetch, not from the shifted register.
- STOP:
  - tx = 1 for STOP_BITS × BIT_CYC cycles.
  - tx_done pulses for 1 cycle in the final cycle of the stop period.
- End of STOP:
  - If fifo_empty = 0: assert fifo_rd and latch in that same final stop cycle, then go directly to START. Start edge follows the stop bit with no idle gap.
  - Otherwise go to IDLE.
- tx_busy = 1 in START, DATA, PARITY and STOP, and also in the fetch cycle.
- tx is registered, so there are no glitches.
- Latency: !empty seen in IDLE at edge N → fifo_rd high in cycle N → tx falls at edge N+1.
- fifo_rd is never asserted while fifo_empty = 1, and at most once per frame.
- fifo_empty toggling mid-frame has no effect until the stop-bit end.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) × BIT_CYC cycles.

Test Plan:
- Basic frame: BIT_CYC = 4 (CLK_FREQ = 4, BAUD_RATE = 1), FIFO holds 8'hA5 → exactly one fifo_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses at cycle 40 after the fetch; tx_busy back to 0.
- Back-to-back: FIFO holds 8'h41, 8'h42 → second start bit immediately follows the first stop bit (no idle cycle); 2 fifo_rd pulses, 2 tx_done pulses, 80 cycles total.
- Parity: PARITY_EN = 1, PARITY_ODD = 0, byte 8'h07 → parity bit 1; PARITY_ODD = 1 → parity bit 0; STOP_BITS = 2 → stop held high 8 cycles.
- Empty source: fifo_empty held 1 for 100 cycles → tx = 1, fifo_rd = 0, tx_busy = 0 throughout.
- Reset mid-frame: rst = 0 during DATA bit 3 → next edge tx = 1, tx_busy = 0; after release with FIFO holding 8'h55, a clean full frame of 8'h55 is sent.
- Default parameters: 100 MHz, 9600 → BIT_CYC = 10416; measured start-bit width is exactly 10416 cycles.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
//   UART transmitter that pulls bytes from a first-word-fall-through FIFO and
//   sends each one as an LSB-first frame: start bit, 8 data bits, an optional
//   parity bit, then 1 or 2 stop bits. When the FIFO still holds data at the
//   end of the last stop bit, the next byte is fetched in that same cycle, so
//   consecutive frames follow each other with no idle gap.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   line bit rate; one bit lasts CLK_FREQ/BAUD_RATE clocks
//   PARITY_EN   1 inserts a parity bit after D7
//   PARITY_ODD  0 = even parity, 1 = odd parity
//   STOP_BITS   1 or 2 stop bits
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   fifo_empty  source FIFO empty flag
//   fifo_rdata  source FIFO head byte (valid while fifo_empty = 0)
//   fifo_rd     one-cycle pop strobe to the source FIFO
//   tx          serial line, idles high, registered
//   tx_busy     high while a frame is in flight, including the fetch cycle
//   tx_done     one-cycle pulse in the final cycle of the stop period

module uart_fifo_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             tx_q;

    logic bit_end;
    logic stop_last;
    logic fetch;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // In STOP the bit index counts stop bits, so the second stop bit is the
    // last one when two are configured.
    assign stop_last = (STOP_BITS < 2) || bit_idx[0];

    // A fetch happens either from IDLE or in the very last stop cycle; it is
    // combinational so the FIFO head is popped in the same cycle it is latched.
    assign fetch = rst && !fifo_empty &&
                   ((state == IDLE) || ((state == STOP) && bit_end && stop_last));

    assign fifo_rd = fetch;
    assign tx_busy = (state != IDLE) || fetch;
    assign tx_done = rst && (state == STOP) && bit_end && stop_last;
    assign tx      = tx_q;

    // Frame sequencer. The tx register is loaded with the value of the bit
    // that the next state will put on the line, so tx changes exactly on the
    // edge where the state changes and never glitches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (fetch) begin
                        shreg   <= fifo_rdata;
                        par_bit <= (^fifo_rdata) ^ PAR_ODD_BIT;
                        state   <= START;
                        tx_q    <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_q     <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx_q  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= STOP;
                        tx_q     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!stop_last) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else if (fetch) begin
                            // Chain straight into the next frame.
                            bit_idx <= '0;
                            shreg   <= fifo_rdata;
                            par_bit <= (^fifo_rdata) ^ PAR_ODD_BIT;
                            state   <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            bit_idx <= '0;
                            state   <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx_q     <= 1'b1;
                end
            endcase
        end
    end

endmodule
